// File: rtl/bus_gate_mux_if.sv
// Bus-side signal bundle for bus_gate_mux: gated sources in, registered bus out.
// conflict_cnt and CNT_W exist only when BUS_CONFLICT_CNT_EN is defined.
interface bus_gate_mux_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N_SRC = 4
`ifdef BUS_CONFLICT_CNT_EN
  ,
  parameter int unsigned CNT_W = 8
`endif
) ();
  localparam int unsigned SrcW = $clog2(N_SRC);

  logic [N_SRC-1:0]       gate;
  logic [N_SRC*WIDTH-1:0] src_data;
  logic                   in_ready;
  logic [WIDTH-1:0]       bus_out;
  logic                   bus_valid;
  logic                   bus_ready;
  logic [SrcW-1:0]        bus_src;
  logic                   conflict;
  logic                   clr_conflict;
`ifdef BUS_CONFLICT_CNT_EN
  logic [CNT_W-1:0]       conflict_cnt;
`endif

  modport master (
    output gate, src_data, bus_ready, clr_conflict,
    input  in_ready, bus_out, bus_valid, bus_src, conflict
`ifdef BUS_CONFLICT_CNT_EN
    , input conflict_cnt
`endif
  );

  modport slave (
    input  gate, src_data, bus_ready, clr_conflict,
    output in_ready, bus_out, bus_valid, bus_src, conflict
`ifdef BUS_CONFLICT_CNT_EN
    , output conflict_cnt
`endif
  );
endinterface

// File: rtl/bus_gate_mux.sv
// Merges N_SRC gated sources onto one registered bus; lowest-index gate wins, 2-entry skid.
// Define BUS_CONFLICT_CNT_EN to add the saturating conflict_cnt output.
module bus_gate_mux #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N_SRC = 4
`ifdef BUS_CONFLICT_CNT_EN
  ,
  parameter int unsigned CNT_W = 8
`endif
) (
  input logic           Clk,
  input logic           Reset_n,
  bus_gate_mux_if.slave bus
);
  localparam int unsigned SrcW = $clog2(N_SRC);

  logic [WIDTH-1:0] out_q, out_d, skid_q, skid_d;
  logic [SrcW-1:0]  src_q, src_d, skid_src_q, skid_src_d;
  logic             valid_q, valid_d, skid_valid_q, skid_valid_d;
  logic             conflict_q, conflict_d;
  logic [SrcW-1:0]  win_idx;
  logic [WIDTH-1:0] win_data;
  logic             accept, multi, conf_hit, drain;

  // Scan downward so the lowest set gate is the last one written.
  always_comb begin
    win_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (bus.gate[i]) win_idx = SrcW'(i);
    end
  end

  assign win_data = bus.src_data[win_idx*WIDTH +: WIDTH];
  assign accept   = (|bus.gate) & ~skid_valid_q;
  assign multi    = |(bus.gate & (bus.gate - N_SRC'(1)));
  assign conf_hit = accept & multi;
  assign drain    = ~valid_q | bus.bus_ready;

  always_comb begin
    out_d        = out_q;
    src_d        = src_q;
    valid_d      = valid_q;
    skid_d       = skid_q;
    skid_src_d   = skid_src_q;
    skid_valid_d = skid_valid_q;
    if (drain) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        src_d        = skid_src_q;
        valid_d      = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d   = win_data;
        src_d   = win_idx;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = win_data;
      skid_src_d   = win_idx;
      skid_valid_d = 1'b1;
    end
  end

  always_comb begin
    conflict_d = conflict_q;
    if (conf_hit) conflict_d = 1'b1;
    else if (bus.clr_conflict) conflict_d = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_q        <= '0;
      src_q        <= '0;
      valid_q      <= 1'b0;
      skid_q       <= '0;
      skid_src_q   <= '0;
      skid_valid_q <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      out_q        <= out_d;
      src_q        <= src_d;
      valid_q      <= valid_d;
      skid_q       <= skid_d;
      skid_src_q   <= skid_src_d;
      skid_valid_q <= skid_valid_d;
      conflict_q   <= conflict_d;
    end
  end

  assign bus.in_ready  = ~skid_valid_q;
  assign bus.bus_out   = out_q;
  assign bus.bus_src   = src_q;
  assign bus.bus_valid = valid_q;
  assign bus.conflict  = conflict_q;

`ifdef BUS_CONFLICT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (bus.clr_conflict) cnt_d = conf_hit ? CNT_W'(1) : '0;
    else if (conf_hit && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign bus.conflict_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_bus_gate_mux.sv
// Bench for bus_gate_mux: directed scenarios plus random traffic against a queue-based model.
module tb_bus_gate_mux;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned N_SRC = 4;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

`ifdef BUS_CONFLICT_CNT_EN
  bus_gate_mux_if #(.WIDTH(WIDTH), .N_SRC(N_SRC), .CNT_W(CNT_W)) bus_if ();
  bus_gate_mux #(.WIDTH(WIDTH), .N_SRC(N_SRC), .CNT_W(CNT_W)) dut (
    .Clk(clk), .Reset_n(rst_n), .bus(bus_if)
  );
`else
  bus_gate_mux_if #(.WIDTH(WIDTH), .N_SRC(N_SRC)) bus_if ();
  bus_gate_mux #(.WIDTH(WIDTH), .N_SRC(N_SRC)) dut (
    .Clk(clk), .Reset_n(rst_n), .bus(bus_if)
  );
`endif

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [1:0]       src;
  } word_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  word_t       q[$];
  word_t       last;
  bit          m_conf;
  int unsigned m_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N_SRC*WIDTH-1:0] mk(input logic [15:0] s0, input logic [15:0] s1,
                                                input logic [15:0] s2, input logic [15:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic model_reset();
    q.delete();
    last   = '0;
    m_conf = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic check_all();
    word_t f;
    if (q.size() != 0) f = q[0];
    else               f = last;
    check_val("bus_valid", 32'(bus_if.bus_valid), 32'(q.size() != 0));
    check_val("bus_out", 32'(bus_if.bus_out), 32'(f.data));
    check_val("bus_src", 32'(bus_if.bus_src), 32'(f.src));
    check_val("in_ready", 32'(bus_if.in_ready), 32'(q.size() < 2));
    check_val("conflict", 32'(bus_if.conflict), 32'(m_conf));
`ifdef BUS_CONFLICT_CNT_EN
    check_val("conflict_cnt", 32'(bus_if.conflict_cnt), m_cnt);
`endif
  endtask

  // Called at a falling edge: drive, advance the model across the next rising edge, then check.
  task automatic step(input logic [N_SRC-1:0] g, input logic [N_SRC*WIDTH-1:0] d,
                      input bit rdy, input bit clr);
    bit    acc, take;
    int    w;
    word_t nw;
    bus_if.gate         = g;
    bus_if.src_data     = d;
    bus_if.bus_ready    = rdy;
    bus_if.clr_conflict = clr;
    acc  = (g != 0) && (q.size() < 2);
    take = (q.size() != 0) && rdy;
    if (take) begin
      last = q[0];
      void'(q.pop_front());
    end
    if (acc) begin
      w = 0;
      for (int i = 0; i < N_SRC; i++) begin
        if (g[i]) begin
          w = i;
          break;
        end
      end
      nw.data = d[w*WIDTH +: WIDTH];
      nw.src  = 2'(w);
      q.push_back(nw);
    end
    if (acc && ($countones(g) > 1)) begin
      m_conf = 1'b1;
      m_cnt  = clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
    end else if (clr) begin
      m_conf = 1'b0;
      m_cnt  = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    bus_if.gate         = '0;
    bus_if.src_data     = '0;
    bus_if.bus_ready    = 1'b0;
    bus_if.clr_conflict = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_valid", 32'(bus_if.bus_valid), 32'd0);
    check_val("rst_out", 32'(bus_if.bus_out), 32'd0);
    rst_n = 1'b1;
    #1 check_val("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    @(negedge clk);
    check_all();

    // Single gate
    step(4'b0100, mk(16'h1111, 16'h2222, 16'h1234, 16'h4444), 1'b1, 1'b0);
    check_val("t2_out", 32'(bus_if.bus_out), 32'h1234);
    check_val("t2_src", 32'(bus_if.bus_src), 32'd2);

    // Priority and sticky conflict, set beats clear
    step(4'b1010, mk(16'h0, 16'hAAAA, 16'h0, 16'h5555), 1'b1, 1'b0);
    check_val("t3_out", 32'(bus_if.bus_out), 32'hAAAA);
    check_val("t3_src", 32'(bus_if.bus_src), 32'd1);
    check_val("t3_conf", 32'(bus_if.conflict), 32'd1);
    step(4'b0000, '0, 1'b1, 1'b0);
    check_val("t3_sticky", 32'(bus_if.conflict), 32'd1);
    step(4'b0011, mk(16'h0BAD, 16'hBEEF, 16'h0, 16'h0), 1'b1, 1'b1);
    check_val("t3_set_wins", 32'(bus_if.conflict), 32'd1);
    step(4'b0000, '0, 1'b1, 1'b1);
    check_val("t3_cleared", 32'(bus_if.conflict), 32'd0);

    // Backpressure with skid; gates while full are ignored and raise no conflict
    step(4'b0001, mk(16'h0001, 16'h0, 16'h0, 16'h0), 1'b0, 1'b0);
    step(4'b0001, mk(16'h0002, 16'h0, 16'h0, 16'h0), 1'b0, 1'b0);
    check_val("t4_full", 32'(bus_if.in_ready), 32'd0);
    step(4'b0011, mk(16'h0003, 16'h0033, 16'h0, 16'h0), 1'b0, 1'b0);
    check_val("t4_ign_conf", 32'(bus_if.conflict), 32'd0);
    check_val("t4_head", 32'(bus_if.bus_out), 32'h0001);
    step(4'b0000, '0, 1'b1, 1'b0);
    check_val("t4_second", 32'(bus_if.bus_out), 32'h0002);
    check_val("t4_second_v", 32'(bus_if.bus_valid), 32'd1);
    step(4'b0000, '0, 1'b1, 1'b0);
    check_val("t4_empty", 32'(bus_if.bus_valid), 32'd0);

    // Idle hold
    repeat (10) step(4'b0000, {$urandom, $urandom}, 1'($urandom), 1'b0);
    check_val("t5_out", 32'(bus_if.bus_out), 32'h0002);
    check_val("t5_src", 32'(bus_if.bus_src), 32'd0);
    check_val("t5_valid", 32'(bus_if.bus_valid), 32'd0);

`ifdef BUS_CONFLICT_CNT_EN
    step(4'b0000, '0, 1'b1, 1'b1);
    repeat (5) step(4'b0011, {$urandom, $urandom}, 1'b1, 1'b0);
    check_val("t6_sat", 32'(bus_if.conflict_cnt), 32'd3);
    step(4'b0000, '0, 1'b1, 1'b1);
    check_val("t6_clr", 32'(bus_if.conflict_cnt), 32'd0);
`endif

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom),
           {$urandom, $urandom},
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset while stalled with the skid full
    step(4'b0000, '0, 1'b1, 1'b0);
    step(4'b0000, '0, 1'b1, 1'b0);
    step(4'b0110, mk(16'h0, 16'hC0DE, 16'hF00D, 16'h0), 1'b0, 1'b0);
    step(4'b0001, mk(16'h7777, 16'h0, 16'h0, 16'h0), 1'b0, 1'b0);
    check_val("t1_full", 32'(bus_if.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_val("t1_valid", 32'(bus_if.bus_valid), 32'd0);
    check_val("t1_out", 32'(bus_if.bus_out), 32'd0);
    check_val("t1_conf", 32'(bus_if.conflict), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_val("t1_in_ready", 32'(bus_if.in_ready), 32'd1);
    check_all();
    step(4'b1000, mk(16'h0, 16'h0, 16'h0, 16'h9999), 1'b1, 1'b0);
    step(4'b0000, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
